fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequences instruction fetch: owns the fetch PC register and issues one-outstanding requests to IMEM.
//  Applies trap/mispredict redirects at any point in a fetch; drops stale responses; holds the fetched instr under decode stall.
//  Sits between IMEM and the IF/ID register; the branch predictor reads pc_f and returns pred_taken/pc_pred combinationally.
// PARAMETERS
//  RESET_PC   32'h0000_0000   address of first fetch after reset
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  stall_f        in   1   decode cannot accept an instruction this cycle
//  trap_redir     in   1   trap/xret redirect, highest priority
//  trap_addr      in   32  trap redirect target
//  mispredict     in   1   EX-stage control-flow mispredict
//  cflow_taken    in   1   resolved outcome: 1 -> pc_jump, 0 -> pc_return
//  pc_jump        in   32  resolved taken target
//  pc_return      in   32  resolved fall-through target
//  pred_taken     in   1   predictor says taken for pc_f
//  pc_pred        in   32  predicted target for pc_f
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch address (= pc_q)
//  imem_gnt       in   1   request accepted this cycle
//  imem_rvalid    in   1   response valid (>=1 cycle after gnt)
//  imem_rdata     in   32  response instruction
//  instr_valid_f  out  1   instr_f/pc_f valid for decode
//  instr_f        out  32  fetched instruction
//  pc_f           out  32  address of instr_f
//  pcplus4_f      out  32  pc_f + 4, mod 2^32
// BEHAVIOUR
//  Reset (async, rst_n=0): pc_q=RESET_PC, state=FETCH, hold buffer empty; imem_req=0, instr_valid_f=0, instr_f=0.
//  States: FETCH (drive req), WAIT (granted, awaiting rvalid), HOLD (instr buffered, stall_f=1), DISCARD (stale rsp in flight).
//  Redirect = trap_redir | mispredict. Target: trap_redir ? trap_addr : (cflow_taken ? pc_jump : pc_return).
//  Trap wins over a simultaneous mispredict.
//  FETCH: imem_req=1, imem_addr=pc_q. gnt & !redirect -> WAIT.
//   redirect -> imem_req forced 0 this cycle; pc_q<=target; stay FETCH.
//  WAIT: rvalid & !redirect & !stall_f -> instr_valid_f=1 this cycle (instr_f=imem_rdata, pc_f=pc_q).
//   pc_q <= pred_taken ? pc_pred : pc_q+4; -> FETCH.
//  WAIT: rvalid & !redirect & stall_f -> capture rdata into hold buffer; -> HOLD.
//  WAIT: redirect & !rvalid -> pc_q<=target; -> DISCARD.
//   redirect & rvalid -> response dropped, pc_q<=target; -> FETCH.
//  HOLD: instr_valid_f=1 from buffer, pc_f=pc_q, stable while stall_f=1.
//   !stall_f -> pc_q <= pred?pc_pred:pc_q+4; -> FETCH.
//   redirect -> buffer flushed, instr_valid_f=0 that cycle, pc_q<=target; -> FETCH.
//  DISCARD: imem_req=0, instr_valid_f=0. rvalid -> drop, -> FETCH. Repeated redirect updates pc_q, stays DISCARD.
//  Latency: first delivery at >=2 cycles after reset release (req+gnt, rvalid); zero-bubble back-to-back not required.
//  pred_taken/pc_pred sampled only on a delivering cycle; ignored otherwise.
//  pcplus4_f = pc_q+4, wraps 32'hFFFF_FFFC -> 0. No alignment check (trap unit owns misalign).
//  instr_valid_f combinational from state/rvalid/redirect; all other state registered.
// STRUCTURE
//  riscv_defines: typedef enum logic [1:0] {FETCH, WAIT, HOLD, DISCARD} fetch_state_e; localparam RESET_PC default.
//  Single module; next-PC priority mux and hold buffer are inline, no sub-module.
// TESTING
//  Reset release, gnt same cycle, rvalid next -> instr_valid_f=1, pc_f=0, pcplus4_f=4, next imem_addr=4.
//  pred_taken=1, pc_pred=0x100 on delivery of pc 0x8 -> next imem_addr=0x100.
//  Mispredict in WAIT (cflow_taken=1, pc_jump=0x40), rvalid 3 cycles later -> rsp dropped; next imem_addr=0x40.
//  Trap (0x80) + mispredict (pc_return=0x20) same cycle -> imem_addr=0x80.
//  stall_f=1 for 4 cycles at rvalid -> instr_f/pc_f stable, imem_req=0; stall drop -> advance by 4.
//  rst_n low mid-WAIT -> outputs zero at once; later stale rvalid ignored; first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    WAIT    = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one-outstanding IMEM
// requests, applies redirects, drops stale responses and holds under decode stall.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            trap_redir,
  input  logic [XLEN-1:0] trap_addr,
  input  logic            mispredict,
  input  logic            cflow_taken,
  input  logic [XLEN-1:0] pc_jump,
  input  logic [XLEN-1:0] pc_return,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pc_pred,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid_f,
  output logic [XLEN-1:0] instr_f,
  output logic [XLEN-1:0] pc_f,
  output logic [XLEN-1:0] pcplus4_f
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            redirect;
  logic [XLEN-1:0] redir_target;
  logic [XLEN-1:0] pc_seq;

  // Trap outranks a same-cycle mispredict.
  assign redirect     = trap_redir | mispredict;
  assign redir_target = trap_redir ? trap_addr : (cflow_taken ? pc_jump : pc_return);

  assign pcplus4_f = pc_q + XLEN'(4);
  assign pc_seq    = pred_taken ? pc_pred : pcplus4_f;
  assign imem_addr = pc_q;
  assign pc_f      = pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    imem_req      = 1'b0;
    instr_valid_f = 1'b0;
    instr_f       = '0;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d = redir_target;
        end else begin
          // Request is suppressed while reset is asserted.
          imem_req = rst_n;
          if (imem_gnt) state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = redir_target;
          state_d = imem_rvalid ? FETCH : DISCARD;
        end else if (imem_rvalid) begin
          if (stall_f) begin
            hold_d  = imem_rdata;
            state_d = HOLD;
          end else begin
            instr_valid_f = 1'b1;
            instr_f       = imem_rdata;
            pc_d          = pc_seq;
            state_d       = FETCH;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = redir_target;
          hold_d  = '0;
          state_d = FETCH;
        end else begin
          instr_valid_f = 1'b1;
          instr_f       = hold_q;
          if (!stall_f) begin
            pc_d    = pc_seq;
            state_d = FETCH;
          end
        end
      end
      DISCARD: begin
        // Response to the abandoned request is still in flight; swallow it.
        if (redirect) pc_d = redir_target;
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a queue-based scoreboard on decode deliveries.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_f, trap_redir, mispredict, cflow_taken, pred_taken;
  logic [31:0] trap_addr, pc_jump, pc_return, pc_pred;
  logic        imem_req, imem_gnt, imem_rvalid, instr_valid_f;
  logic [31:0] imem_addr, imem_rdata, instr_f, pc_f, pcplus4_f;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall_f(stall_f),
    .trap_redir(trap_redir), .trap_addr(trap_addr),
    .mispredict(mispredict), .cflow_taken(cflow_taken),
    .pc_jump(pc_jump), .pc_return(pc_return),
    .pred_taken(pred_taken), .pc_pred(pc_pred),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid_f(instr_valid_f), .instr_f(instr_f),
    .pc_f(pc_f), .pcplus4_f(pcplus4_f)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every presented instruction; consume only when decode accepts it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid_f === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_delivery: pc %h instr %h with empty scoreboard", pc_f, instr_f);
      end else begin
        check("deliver_pc", pc_f, exp_q[0].pc);
        check("deliver_instr", instr_f, exp_q[0].instr);
        check("deliver_pcplus4", pcplus4_f, exp_q[0].pcplus4);
        if (!stall_f) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_f = 0; trap_redir = 0; mispredict = 0; cflow_taken = 0; pred_taken = 0;
    trap_addr = '0; pc_jump = '0; pc_return = '0; pc_pred = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  // One clean fetch: grant in FETCH, response the next cycle, delivered immediately.
  task automatic fetch_one(input logic [31:0] exp_pc, input logic [31:0] data,
                           input logic pt, input logic [31:0] pp);
    imem_gnt = 1;
    #1;
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    step();
    imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = data; pred_taken = pt; pc_pred = pp;
    exp_q.push_back('{pc: exp_pc, instr: data, pcplus4: exp_pc + 32'd4});
    step();
    imem_rvalid = 0; imem_rdata = '0; pred_taken = 0; pc_pred = '0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time %0t exceeded limit 20000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 0;
    #12;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid_f), 32'd0);
    check("rst_instr", instr_f, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_pcplus4", pcplus4_f, 32'h4);
    step();
    rst_n = 1;

    // Sequential fetches, then a predicted-taken redirect to 0x100.
    fetch_one(32'h0, 32'h0000_0013, 0, '0);
    fetch_one(32'h4, 32'h1111_1111, 0, '0);
    fetch_one(32'h8, 32'h2222_2222, 1, 32'h100);
    fetch_one(32'h100, 32'h3333_3333, 0, '0);

    // Mispredict while WAIT; response arrives 3 cycles later and is dropped.
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    mispredict = 1; cflow_taken = 1; pc_jump = 32'h40;
    step();
    mispredict = 0; cflow_taken = 0; pc_jump = '0;
    #1;
    check("discard_req", 32'(imem_req), 32'd0);
    check("discard_addr", imem_addr, 32'h40);
    step();
    step();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("discard_valid", 32'(instr_valid_f), 32'd0);
    step();
    imem_rvalid = 0; imem_rdata = '0;
    fetch_one(32'h40, 32'h4444_4444, 0, '0);

    // Trap and mispredict together in FETCH: trap target wins.
    trap_redir = 1; trap_addr = 32'h80;
    mispredict = 1; cflow_taken = 0; pc_return = 32'h20;
    #1;
    check("redir_req_forced_low", 32'(imem_req), 32'd0);
    step();
    idle_inputs();
    fetch_one(32'h80, 32'h5555_5555, 0, '0);

    // Response under stall: held stable 4 cycles, then advance by 4.
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    imem_rvalid = 1; imem_rdata = 32'h6666_6666; stall_f = 1;
    exp_q.push_back('{pc: 32'h84, instr: 32'h6666_6666, pcplus4: 32'h88});
    step();
    imem_rvalid = 0; imem_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_req", 32'(imem_req), 32'd0);
      step();
    end
    stall_f = 0;
    step();
    fetch_one(32'h88, 32'h7777_7777, 0, '0);

    // Reset asserted mid-WAIT; the late response must be ignored.
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    #2;
    rst_n = 0;
    #1;
    check("midrst_req", 32'(imem_req), 32'd0);
    check("midrst_valid", 32'(instr_valid_f), 32'd0);
    check("midrst_instr", instr_f, 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    step();
    rst_n = 1;
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("stale_valid", 32'(instr_valid_f), 32'd0);
    step();
    imem_rvalid = 0; imem_rdata = '0;
    fetch_one(32'h0, 32'h8888_8888, 0, '0);

    step();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
